// File: rtl/shift_pipe_if.sv
// Operand/result handshake bundle for shift_pipe.
// slave : the shifter's view (operand in, result out).
// master: the driving environment's view.
//   clear_i   synchronous flush of in-flight operations
//   valid_i / ready_o / x_i / amount_i / mode_i   operand side
//   valid_o / ready_i / y_o                        result side
interface shift_pipe_if #(
  parameter int unsigned Width    = 16,
  parameter int unsigned AmtWidth = 4
);
  logic                clear_i;
  logic                valid_i;
  logic                ready_o;
  logic [Width-1:0]    x_i;
  logic [AmtWidth-1:0] amount_i;
  logic [1:0]          mode_i;
  logic                valid_o;
  logic                ready_i;
  logic [Width-1:0]    y_o;

  modport slave (
    input  clear_i, valid_i, x_i, amount_i, mode_i, ready_i,
    output ready_o, valid_o, y_o
  );

  modport master (
    output clear_i, valid_i, x_i, amount_i, mode_i, ready_i,
    input  ready_o, valid_o, y_o
  );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: stage k shifts by 2^k when amount bit k is set.
// Modes: 00 arithmetic right, 01 logical right, 10 logical left, 11 rotate right.
// Amounts >= Width saturate (except rotate, which wraps modulo Width).
// Ports:
//   clk_i   rising-edge clock
//   rst_ni  asynchronous active-low reset
//   bus     shift_pipe_if.slave (clear, operand handshake, result handshake)
module shift_pipe #(
  parameter int unsigned Width    = 16,
  parameter int unsigned AmtWidth = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  shift_pipe_if.slave  bus
);

  localparam int unsigned Last = AmtWidth - 1;

  typedef enum logic [1:0] {
    ModeAsr = 2'b00,
    ModeLsr = 2'b01,
    ModeLsl = 2'b10,
    ModeRor = 2'b11
  } mode_e;

  // Per-stage payload and control
  logic [Width-1:0]    data_q [AmtWidth];
  logic [Width-1:0]    data_d [AmtWidth];
  logic [AmtWidth-1:0] amt_q  [AmtWidth];
  logic [AmtWidth-1:0] amt_d  [AmtWidth];
  mode_e               mode_q [AmtWidth];
  mode_e               mode_d [AmtWidth];
  logic [AmtWidth-1:0] sign_q, sign_d;
  logic [AmtWidth-1:0] sat_q, sat_d;
  logic [AmtWidth-1:0] vld_q, vld_d;

  // Flow control
  logic [AmtWidth-1:0] load_c;
  logic [AmtWidth-1:0] adv_c;
  logic                ready_c;
  logic                sat_in_c;

  // Stage source selection (scratch for the datapath block)
  logic                src_vld;
  logic [Width-1:0]    src_data;
  logic [AmtWidth-1:0] src_amt;
  mode_e               src_mode;
  logic                src_sign;
  logic                src_sat;
  logic [Width-1:0]    res;

  // One shift step by s bit positions in the given mode.
  function automatic logic [Width-1:0] shift_by(input logic [Width-1:0] d,
                                                input mode_e m,
                                                input int unsigned s);
    logic [Width-1:0] r;
    int unsigned      rot;
    rot = s % Width;
    case (m)
      ModeAsr: r = $signed(d) >>> s;
      ModeLsr: r = d >> s;
      ModeLsl: r = d << s;
      default: r = (d >> rot) | (d << (Width - rot));
    endcase
    return r;
  endfunction

  // Result for an out-of-range amount; rotate passes its wrapped value through.
  function automatic logic [Width-1:0] sat_value(input logic [Width-1:0] d,
                                                 input mode_e m,
                                                 input logic sign);
    logic [Width-1:0] r;
    case (m)
      ModeAsr: r = {Width{sign}};
      ModeLsr: r = '0;
      ModeLsl: r = '0;
      default: r = d;
    endcase
    return r;
  endfunction

  // Saturation is only reachable when the amount range exceeds the data width.
  if ((64'd1 << AmtWidth) > 64'(Width)) begin : g_sat
    assign sat_in_c = (bus.amount_i >= AmtWidth'(Width));
  end else begin : g_nosat
    assign sat_in_c = 1'b0;
  end

  // Load/advance chain, resolved from the output back towards the input.
  always_comb begin
    adv_c  = '0;
    load_c = '0;
    adv_c[Last] = bus.ready_i;
    for (int k = int'(Last); k >= 0; k--) begin
      load_c[k] = !vld_q[k] || adv_c[k];
      if (k > 0) begin
        adv_c[k-1] = load_c[k];
      end
    end
  end

  assign ready_c     = load_c[0] && !bus.clear_i;
  assign bus.ready_o = ready_c;

  // Next-state datapath; data only moves with a valid operand so y_o holds.
  always_comb begin
    data_d   = data_q;
    amt_d    = amt_q;
    mode_d   = mode_q;
    sign_d   = sign_q;
    sat_d    = sat_q;
    vld_d    = vld_q;
    src_vld  = 1'b0;
    src_data = '0;
    src_amt  = '0;
    src_mode = ModeAsr;
    src_sign = 1'b0;
    src_sat  = 1'b0;
    res      = '0;
    for (int k = 0; k < int'(AmtWidth); k++) begin
      if (k == 0) begin
        src_vld  = bus.valid_i && ready_c;
        src_data = bus.x_i;
        src_amt  = bus.amount_i;
        src_mode = mode_e'(bus.mode_i);
        src_sign = bus.x_i[Width-1];
        src_sat  = sat_in_c;
      end else begin
        src_vld  = vld_q[k-1];
        src_data = data_q[k-1];
        src_amt  = amt_q[k-1];
        src_mode = mode_q[k-1];
        src_sign = sign_q[k-1];
        src_sat  = sat_q[k-1];
      end

      res = src_amt[k] ? shift_by(src_data, src_mode, 32'd1 << k) : src_data;
      if ((k == int'(Last)) && src_sat) begin
        res = sat_value(res, src_mode, src_sign);
      end

      if (bus.clear_i) begin
        vld_d[k] = 1'b0;
      end else if (load_c[k]) begin
        vld_d[k] = src_vld;
        if (src_vld) begin
          data_d[k] = res;
          amt_d[k]  = src_amt;
          mode_d[k] = src_mode;
          sign_d[k] = src_sign;
          sat_d[k]  = src_sat;
        end
      end
    end
  end

  // Stage registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < int'(AmtWidth); k++) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
        mode_q[k] <= ModeAsr;
      end
      sign_q <= '0;
      sat_q  <= '0;
      vld_q  <= '0;
    end else begin
      data_q <= data_d;
      amt_q  <= amt_d;
      mode_q <= mode_d;
      sign_q <= sign_d;
      sat_q  <= sat_d;
      vld_q  <= vld_d;
    end
  end

  assign bus.valid_o = vld_q[Last];
  assign bus.y_o     = data_q[Last];

  // Final-stage control fields are kept for a uniform stage layout but have no consumer.
  logic unused_last_ctrl;
  assign unused_last_ctrl = ^{amt_q[Last], mode_q[Last], sign_q[Last], sat_q[Last]};

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: directed vector table on 16- and 12-bit instances,
// plus randomized traffic on the 16-bit instance against a bit-level model.
module tb_shift_pipe;

  typedef struct {
    int          w;
    logic [15:0] x;
    logic [3:0]  amt;
    logic [1:0]  mode;
    logic [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  shift_pipe_if #(.Width(16), .AmtWidth(4)) b16 ();
  shift_pipe_if #(.Width(12), .AmtWidth(4)) b12 ();

  shift_pipe #(.Width(16), .AmtWidth(4)) u_dut16 (.clk_i(clk), .rst_ni(rst_n), .bus(b16));
  shift_pipe #(.Width(12), .AmtWidth(4)) u_dut12 (.clk_i(clk), .rst_ni(rst_n), .bus(b12));

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  int unsigned pop_cyc[$];
  int unsigned cyc = 0;
  vec_t        tbl[16];

  task automatic check(input bit ok, input string name, input logic [31:0] got,
                       input logic [31:0] want);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: each output bit picked from its source bit by the mode's rule.
  function automatic logic [15:0] model(input int w, input logic [15:0] x,
                                        input int amt, input logic [1:0] mode);
    logic [15:0] y;
    logic        sign;
    y    = '0;
    sign = x[w-1];
    for (int i = 0; i < w; i++) begin
      case (mode)
        2'd0:    y[i] = (i + amt < w) ? x[i+amt] : sign;
        2'd1:    y[i] = (i + amt < w) ? x[i+amt] : 1'b0;
        2'd2:    y[i] = (i >= amt) ? x[i-amt] : 1'b0;
        default: y[i] = x[(i + amt) % w];
      endcase
    end
    return y;
  endfunction

  function automatic logic valid_of(input int w);
    return (w == 16) ? b16.valid_o : b12.valid_o;
  endfunction

  function automatic logic ready_of(input int w);
    return (w == 16) ? b16.ready_o : b12.ready_o;
  endfunction

  function automatic logic [15:0] y_of(input int w);
    return (w == 16) ? b16.y_o : 16'(b12.y_o);
  endfunction

  task automatic set_in(input int w, input logic v, input logic [15:0] x,
                        input logic [3:0] amt, input logic [1:0] mode);
    if (w == 16) begin
      b16.valid_i = v; b16.x_i = x; b16.amount_i = amt; b16.mode_i = mode;
    end else begin
      b12.valid_i = v; b12.x_i = 12'(x); b12.amount_i = amt; b12.mode_i = mode;
    end
  endtask

  task automatic drive16(input logic v);
    b16.valid_i  = v;
    b16.x_i      = 16'($urandom);
    b16.amount_i = 4'($urandom_range(0, 15));
    b16.mode_i   = 2'($urandom_range(0, 3));
  endtask

  // Scoreboard on the 16-bit instance, sampled on the falling edge.
  task automatic monitor();
    bit          stall;
    logic [15:0] sy;
    logic [15:0] e;
    stall = 1'b0;
    sy    = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n || b16.clear_i) begin
        exp_q.delete();
        stall = 1'b0;
      end else begin
        if (stall)
          check(b16.valid_o && (b16.y_o == sy), "stall_hold",
                {15'd0, b16.valid_o, b16.y_o}, {15'd0, 1'b1, sy});
        if (b16.valid_o && b16.ready_i) begin
          check(exp_q.size() != 0, "unexpected_out", 32'(b16.y_o), 32'(exp_q.size()));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(b16.y_o == e, "stream_data", 32'(b16.y_o), 32'(e));
            pop_cyc.push_back(cyc);
          end
        end
        if (b16.valid_i && b16.ready_o)
          exp_q.push_back(model(16, b16.x_i, int'(b16.amount_i), b16.mode_i));
        stall = b16.valid_o && !b16.ready_i;
        sy    = b16.y_o;
      end
    end
  endtask

  // One isolated operand; checks exact latency and the result.
  task automatic apply_vec(input int idx, input vec_t v);
    set_in(v.w, 1'b1, v.x, v.amt, v.mode);
    @(negedge clk);
    check(ready_of(v.w), $sformatf("vec_ready[%0d]", idx), 32'(ready_of(v.w)), 32'd1);
    @(posedge clk); #1;
    set_in(v.w, 1'b0, v.x, v.amt, v.mode);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(!valid_of(v.w), $sformatf("vec_early[%0d]", idx), 32'(valid_of(v.w)), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check(valid_of(v.w) && (y_of(v.w) == v.exp), $sformatf("vec_result[%0d]", idx),
          {15'd0, valid_of(v.w), y_of(v.w)}, {15'd0, 1'b1, v.exp});
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int k;
    b16.valid_i = 1'b0;
    b16.ready_i = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || b16.valid_o) && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    check(exp_q.size() == 0 && !b16.valid_o, name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int          acc;
    int unsigned pb;
    logic [15:0] sy;
    logic [15:0] e;

    tbl[0]  = '{16, 16'h8000, 4'd3,  2'd0, 16'hF000};
    tbl[1]  = '{16, 16'h8000, 4'd3,  2'd1, 16'h1000};
    tbl[2]  = '{16, 16'h0001, 4'd15, 2'd2, 16'h8000};
    tbl[3]  = '{16, 16'h0001, 4'd1,  2'd3, 16'h8000};
    tbl[4]  = '{16, 16'hA5A5, 4'd0,  2'd0, 16'hA5A5};
    tbl[5]  = '{16, 16'hA5A5, 4'd0,  2'd2, 16'hA5A5};
    tbl[6]  = '{16, 16'h8000, 4'd15, 2'd0, 16'hFFFF};
    tbl[7]  = '{16, 16'h1234, 4'd4,  2'd3, 16'h4123};
    tbl[8]  = '{12, 16'h0800, 4'd13, 2'd0, 16'h0FFF};
    tbl[9]  = '{12, 16'h0800, 4'd13, 2'd1, 16'h0000};
    tbl[10] = '{12, 16'h0800, 4'd13, 2'd2, 16'h0000};
    tbl[11] = '{12, 16'h0001, 4'd13, 2'd3, 16'h0800};
    tbl[12] = '{12, 16'h0123, 4'd12, 2'd3, 16'h0123};
    tbl[13] = '{12, 16'h07FF, 4'd12, 2'd0, 16'h0000};
    tbl[14] = '{12, 16'h0C01, 4'd11, 2'd1, 16'h0001};
    tbl[15] = '{16, 16'hF00F, 4'd4,  2'd2, 16'h00F0};

    rst_n = 1'b0;
    b16.clear_i = 1'b0; b16.ready_i = 1'b1;
    b12.clear_i = 1'b0; b12.ready_i = 1'b1;
    set_in(16, 1'b0, '0, '0, '0);
    set_in(12, 1'b0, '0, '0, '0);

    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    #1;
    check(!b16.valid_o, "rst_valid16", 32'(b16.valid_o), 32'd0);
    check(b16.y_o == 16'h0, "rst_y16", 32'(b16.y_o), 32'd0);
    check(b16.ready_o, "rst_ready16", 32'(b16.ready_o), 32'd1);
    check(!b12.valid_o, "rst_valid12", 32'(b12.valid_o), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 16; i++) apply_vec(i, tbl[i]);

    // Streaming: 32 back-to-back operands
    pb = pop_cyc.size();
    for (int i = 0; i < 32; i++) begin
      drive16(1'b1);
      @(negedge clk);
      check(b16.ready_o, "stream_ready", 32'(b16.ready_o), 32'd1);
      @(posedge clk); #1;
    end
    drain("stream_drain");
    check(pop_cyc.size() - pb == 32, "stream_count", 32'(pop_cyc.size() - pb), 32'd32);
    if (pop_cyc.size() - pb == 32)
      check(pop_cyc[pb+31] - pop_cyc[pb] == 31, "stream_consecutive",
            32'(pop_cyc[pb+31] - pop_cyc[pb]), 32'd31);

    // Backpressure: 6 offered, 4 accepted
    b16.ready_i = 1'b0;
    acc = 0;
    pb = pop_cyc.size();
    for (int i = 0; i < 6; i++) begin
      drive16(1'b1);
      @(negedge clk);
      if (b16.ready_o) acc++;
      @(posedge clk); #1;
    end
    b16.valid_i = 1'b0;
    check(acc == 4, "bp_accepted", 32'(acc), 32'd4);
    @(negedge clk);
    check(!b16.ready_o, "bp_full", 32'(b16.ready_o), 32'd0);
    sy = b16.y_o;
    repeat (3) @(negedge clk);
    check(b16.valid_o && b16.y_o == sy, "bp_hold", 32'(b16.y_o), 32'(sy));
    @(posedge clk); #1;
    b16.ready_i = 1'b1;
    #1;
    check(b16.ready_o, "bp_release", 32'(b16.ready_o), 32'd1);
    drain("bp_drain");
    check(pop_cyc.size() - pb == 4, "bp_delivered", 32'(pop_cyc.size() - pb), 32'd4);

    // Flush with 3 in flight and a concurrent operand
    for (int i = 0; i < 3; i++) begin
      drive16(1'b1);
      @(posedge clk); #1;
    end
    drive16(1'b1);
    b16.clear_i = 1'b1;
    @(negedge clk);
    check(!b16.ready_o, "flush_ready", 32'(b16.ready_o), 32'd0);
    @(posedge clk); #1;
    b16.clear_i = 1'b0;
    check(!b16.valid_o, "flush_valid", 32'(b16.valid_o), 32'd0);
    drive16(1'b1);
    e = model(16, b16.x_i, int'(b16.amount_i), b16.mode_i);
    @(posedge clk); #1;
    b16.valid_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(!b16.valid_o, "flush_early", 32'(b16.valid_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check(b16.valid_o && b16.y_o == e, "flush_next", {15'd0, b16.valid_o, b16.y_o},
          {15'd0, 1'b1, e});
    @(posedge clk); #1;
    drain("flush_drain");

    // Asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) begin
      drive16(1'b1);
      @(posedge clk); #1;
    end
    b16.valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check(!b16.valid_o, "arst_valid", 32'(b16.valid_o), 32'd0);
    check(b16.y_o == 16'h0, "arst_y", 32'(b16.y_o), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    check(b16.ready_o, "arst_ready", 32'(b16.ready_o), 32'd1);
    @(posedge clk); #1;
    pb = pop_cyc.size();
    for (int i = 0; i < 5; i++) begin
      drive16(1'b1);
      @(posedge clk); #1;
    end
    drain("arst_drain");
    check(pop_cyc.size() - pb == 5, "arst_count", 32'(pop_cyc.size() - pb), 32'd5);

    // Random traffic with random backpressure
    pb = pop_cyc.size();
    for (int i = 0; i < 300; i++) begin
      drive16(($urandom % 4) != 0);
      b16.ready_i = (($urandom % 3) != 0);
      @(posedge clk); #1;
    end
    drain("rand_drain");
    check(pop_cyc.size() > pb, "rand_progress", 32'(pop_cyc.size() - pb), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
